// File: rtl/ps2_keycode.sv
// ps2_keycode: PS/2 Set-2 receiver that tracks the held game key (D/F/Space/J/K) as a HID keycode.
// Latency: keycode/key_event update 2 cycles after the filtered falling edge that samples the stop bit.
// Backpressure: none; a keyboard cannot be stalled, so every byte is decoded the moment it arrives.
module ps2_keycode #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       pixel_clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       rx_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} frame_state_t;
    typedef enum logic [1:0] {NORM, BRK, EXT, EXTBRK} dec_state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_f;
    logic          fe;
    logic [FW-1:0] filt_cnt;

    frame_state_t  frame_state;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_dat;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          byte_rdy;

    dec_state_t    dec_state;
    logic [7:0]    rx_hid;

    // Set-2 make/break code to HID usage; 0 means the key is not one we track.
    function automatic logic [7:0] to_hid(input logic [7:0] sc);
        case (sc)
            8'h23:   return 8'h07;
            8'h2B:   return 8'h09;
            8'h29:   return 8'h2C;
            8'h3B:   return 8'h0D;
            8'h42:   return 8'h0E;
            default: return 8'h00;
        endcase
    endfunction

    // shift_dat holds the last good byte untouched until the next frame's first data bit.
    assign rx_hid = to_hid(shift_dat);

    // Two-flop synchronizers for both pins; an idle PS/2 bus sits high.
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Debounce the PS/2 clock: follow a new level only after FILTER_LEN agreeing samples,
    // and flag the 1->0 transition for exactly one cycle.
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            clk_f    <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync[1] == clk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_f    <= clk_sync[1];
                filt_cnt <= '0;
                fe       <= clk_f;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame receiver: start, 8 data bits LSB-first, odd parity, stop; a stalled frame is dropped.
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            frame_state <= IDLE;
            bit_idx     <= '0;
            shift_dat   <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            byte_rdy    <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            rx_err   <= 1'b0;

            if (frame_state == IDLE || fe)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            case (frame_state)
                IDLE: begin
                    // A high sample on an edge here is line noise, not a start bit.
                    if (fe && !data_sync[1]) begin
                        frame_state <= DATA;
                        bit_idx     <= '0;
                    end
                end
                DATA: begin
                    if (fe) begin
                        shift_dat <= {data_sync[1], shift_dat[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            frame_state <= PAR;
                    end
                end
                PAR: begin
                    if (fe) begin
                        par_bit     <= data_sync[1];
                        frame_state <= STOP;
                    end
                end
                STOP: begin
                    if (fe) begin
                        frame_state <= IDLE;
                        if (data_sync[1] && (^{shift_dat, par_bit}))
                            byte_rdy <= 1'b1;
                        else
                            rx_err <= 1'b1;
                    end
                end
                default: frame_state <= IDLE;
            endcase

            // Keyboard went quiet mid-frame: abandon whatever was collected.
            if (frame_state != IDLE && !fe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                rx_err      <= 1'b1;
                frame_state <= IDLE;
                tmo_cnt     <= '0;
            end
        end
    end

    // Prefix decoder and held-key tracker; extended (E0) sequences are swallowed entirely.
    always_ff @(posedge pixel_clk) begin
        if (Reset) begin
            dec_state <= NORM;
            keycode   <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (byte_rdy) begin
                case (dec_state)
                    NORM: begin
                        if (shift_dat == 8'hF0) begin
                            dec_state <= BRK;
                        end else if (shift_dat == 8'hE0) begin
                            dec_state <= EXT;
                        end else if (rx_hid != 8'h00 && rx_hid != keycode) begin
                            // Typematic repeats of the held key fall through silently.
                            keycode   <= rx_hid;
                            key_event <= 1'b1;
                        end
                    end
                    BRK: begin
                        dec_state <= NORM;
                        // Releasing a key other than the one shown leaves the display alone.
                        if (rx_hid != 8'h00 && rx_hid == keycode) begin
                            keycode   <= 8'h00;
                            key_event <= 1'b1;
                        end
                    end
                    EXT:     dec_state <= (shift_dat == 8'hF0) ? EXTBRK : NORM;
                    EXTBRK:  dec_state <= NORM;
                    default: dec_state <= NORM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: drives bit-level PS/2 frames into ps2_keycode and compares against a byte-level key model.
// Latency: checks are taken after each frame has fully settled, plus a stop-edge-to-keycode window check.
// Backpressure: not applicable; the bench paces frames itself.
module tb_ps2_keycode;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 300;

    logic       pixel_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic [7:0] keycode;
    logic       key_event;
    logic       rx_err;

    int checks   = 0;
    int failures = 0;

    int cyc             = 0;
    int ev_cnt          = 0;
    int err_cnt         = 0;
    int last_fall_cyc   = 0;
    int last_change_cyc = 0;
    logic [7:0] prev_kc = 8'h00;
    int hp              = 10;

    // Reference model state: held key, expected pulse totals, pending prefix bytes.
    logic [7:0] m_kc    = 8'h00;
    int         exp_ev  = 0;
    int         exp_err = 0;
    logic [7:0] pend[$];

    ps2_keycode #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .pixel_clk (pixel_clk),
        .Reset     (Reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .key_event (key_event),
        .rx_err    (rx_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Pulse counters, and key_event must coincide exactly with a keycode change.
    always @(negedge pixel_clk) begin
        if (!Reset) begin
            if (key_event) ev_cnt++;
            if (rx_err) err_cnt++;
            if (key_event || keycode !== prev_kc) begin
                if (keycode !== prev_kc) last_change_cyc = cyc;
                checks++;
                assert (key_event === (keycode !== prev_kc)) else begin
                    failures++;
                    $error("FAIL key_event_vs_change: key_event=%0b keycode %02h->%02h", key_event, prev_kc, keycode);
                end
            end
        end
        prev_kc = keycode;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] hid_of(input logic [7:0] sc);
        case (sc)
            8'h23:   return 8'h07;
            8'h2B:   return 8'h09;
            8'h29:   return 8'h2C;
            8'h3B:   return 8'h0D;
            8'h42:   return 8'h0E;
            default: return 8'h00;
        endcase
    endfunction

    // A key code is the final byte plus whatever prefixes preceded it (E0, F0, or E0 F0).
    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] h;
        bit is_ext;
        bit is_brk;
        if ((b == 8'hE0 && pend.size() == 0) ||
            (b == 8'hF0 && (pend.size() == 0 || (pend.size() == 1 && pend[0] == 8'hE0)))) begin
            pend.push_back(b);
            return;
        end
        is_ext = 1'b0;
        is_brk = 1'b0;
        foreach (pend[i]) begin
            if (pend[i] == 8'hE0) is_ext = 1'b1;
            if (pend[i] == 8'hF0) is_brk = 1'b1;
        end
        pend.delete();
        h = hid_of(b);
        if (is_ext || h == 8'h00) return;
        if (!is_brk && h != m_kc) begin
            m_kc = h;
            exp_ev++;
        end else if (is_brk && h == m_kc) begin
            m_kc = 8'h00;
            exp_ev++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_keycode"}, {24'h0, keycode}, {24'h0, m_kc});
        chk({tag, "_key_events"}, ev_cnt, exp_ev);
        chk({tag, "_rx_errs"}, err_cnt, exp_err);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (hp) @(negedge pixel_clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (hp) @(negedge pixel_clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ par_flip);
        send_bit(stop_v);
        ps2_data = 1'b1;
        repeat (3 * hp) @(negedge pixel_clk);
        if (par_flip || !stop_v) exp_err++;
        else model_byte(b);
    endtask

    initial begin
        logic [7:0] pool [8];
        int lat;
        pool = '{8'h23, 8'h2B, 8'h29, 8'h3B, 8'h42, 8'hF0, 8'hE0, 8'h00};

        // Reset state
        repeat (4) @(negedge pixel_clk);
        chk("reset_keycode", {24'h0, keycode}, 32'h0);
        chk("reset_key_event", {31'h0, key_event}, 32'h0);
        chk("reset_rx_err", {31'h0, rx_err}, 32'h0);
        Reset = 1'b0;
        repeat (10) @(negedge pixel_clk);

        // Single make of D, with stop-edge-to-keycode latency window
        send_frame(8'h23, 1'b0, 1'b1);
        check_state("make_D");
        chk("make_D_value", {24'h0, keycode}, 32'h07);
        lat = last_change_cyc - last_fall_cyc;
        chk("make_D_latency_in_window", {31'h0, (lat >= FILTER_LEN + 3 && lat <= FILTER_LEN + 5)}, 32'h1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h23, 1'b0, 1'b1);
        check_state("release_D");

        // K with typematic repeat, then release
        send_frame(8'h42, 1'b0, 1'b1);
        check_state("make_K");
        send_frame(8'h42, 1'b0, 1'b1);
        check_state("typematic_K");
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h42, 1'b0, 1'b1);
        check_state("release_K");

        // J held, K pressed, J released: K stays shown
        send_frame(8'h3B, 1'b0, 1'b1);
        check_state("make_J");
        send_frame(8'h42, 1'b0, 1'b1);
        check_state("J_then_K");
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h3B, 1'b0, 1'b1);
        check_state("release_J_keeps_K");
        chk("release_J_keeps_K_value", {24'h0, keycode}, 32'h0E);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h42, 1'b0, 1'b1);

        // Bad parity and bad stop on Space
        send_frame(8'h29, 1'b1, 1'b1);
        check_state("bad_parity");
        send_frame(8'h29, 1'b0, 1'b0);
        check_state("bad_stop");

        // Stalled frame times out, then a clean F
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TIMEOUT_CYCLES + 60) @(negedge pixel_clk);
        exp_err++;
        check_state("timeout");
        send_frame(8'h2B, 1'b0, 1'b1);
        check_state("after_timeout_F");
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h2B, 1'b0, 1'b1);

        // Extended make and break never touch keycode
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        check_state("ext_make");
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        check_state("ext_break");

        // Short ps2_clk glitch with data low must not start a frame
        @(negedge pixel_clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge pixel_clk);
        ps2_clk  = 1'b1;
        repeat (4) @(negedge pixel_clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge pixel_clk);
        send_frame(8'h3B, 1'b0, 1'b1);
        check_state("after_glitch");

        // Reset in the middle of a data phase, held while the frame drains
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        Reset = 1'b1;
        @(negedge pixel_clk);
        chk("midreset_keycode", {24'h0, keycode}, 32'h0);
        chk("midreset_key_event", {31'h0, key_event}, 32'h0);
        chk("midreset_rx_err", {31'h0, rx_err}, 32'h0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (10) @(negedge pixel_clk);
        Reset = 1'b0;
        m_kc = 8'h00;
        pend.delete();
        repeat (10) @(negedge pixel_clk);
        check_state("post_reset");
        send_frame(8'h42, 1'b0, 1'b1);
        check_state("post_reset_K");

        // Randomised frames: mapped keys, prefixes, arbitrary bytes, occasional line errors
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int sel;
            int mode;
            hp   = $urandom_range(8, 12);
            sel  = $urandom_range(0, 7);
            b    = (sel == 7) ? 8'($urandom_range(0, 255)) : pool[sel];
            mode = $urandom_range(0, 9);
            send_frame(b, mode == 0, mode != 1);
            check_state("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_keycode.md
Name: ps2_keycode

Overview:
- Receives PS/2 Set-2 scan codes from the keyboard and produces the 8-bit USB-HID style `keycode` that the tile display logic consumes.
- Only the five game keys are mapped: D=0x07, F=0x09, Space=0x2C, J=0x0D, K=0x0E.
- `keycode` is held non-zero while a mapped key is down and returns to 0 on that key's release.
- Sits between the board PS/2 pins and the game logic, in the pixel_clk domain.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronized samples of `ps2_clk` required before the filtered clock changes.
- TIMEOUT_CYCLES, 25000: pixel_clk cycles without a filtered falling edge mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
- pixel_clk  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  asynchronous PS/2 clock from the pin.
- ps2_data  in  1  asynchronous PS/2 data from the pin.
- keycode  out  8  HID code of the held mapped key; 0 = none.
- key_event  out  1  one-cycle pulse whenever `keycode` changes value.
- rx_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Input synchronization
  - Both pins pass through a 2-FF synchronizer.
  - The synchronized `ps2_clk` feeds the filter. `clk_f` takes the new level only after FILTER_LEN equal consecutive samples; its reset value is 1.
  - A falling edge (`fe`) is `clk_f` going 1->0; `fe` is asserted for exactly one cycle.
  - Data is sampled from synchronized `ps2_data` in the `fe` cycle.
- Frame FSM (states IDLE, DATA, PAR, STOP)
  - IDLE: on `fe` with data=0 (start bit), go to DATA with bit index 0. On `fe` with data=1, stay in IDLE (noise).
  - DATA: on each `fe`, shift the bit into the byte LSB-first. After the 8th bit, go to PAR.
  - PAR: on `fe`, capture the parity bit and go to STOP.
  - STOP: on `fe`, the frame is good if stop=1 and data plus parity has an odd count of ones. A good frame raises the internal `byte_rdy` for one cycle. A bad frame pulses `rx_err` with no byte delivered. Either way, return to IDLE.
  - Timeout: in any non-IDLE state, a counter counts cycles since the last `fe` and is cleared on each `fe`. When it reaches TIMEOUT_CYCLES, pulse `rx_err`, discard the partial frame and return to IDLE.
- Decode FSM (states NORM, BRK, EXT, EXTBRK), advanced only on `byte_rdy`
  - NORM: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code.
  - BRK: the byte is a break code; go to NORM.
  - EXT: 0xF0 -> EXTBRK; any other byte is ignored, go to NORM.
  - EXTBRK: the byte is ignored; go to NORM.
  - Extended keys never affect `keycode`.
- Mapping, Set-2 to HID: 0x23->0x07, 0x2B->0x09, 0x29->0x2C, 0x3B->0x0D, 0x42->0x0E. All other codes are unmapped.
- Make of a mapped key: `keycode` takes its HID value, replacing any held key. Typematic repeat of the same key leaves the value unchanged and produces no `key_event`.
- Break of a mapped key whose HID value equals `keycode`: `keycode` becomes 0.
- Break of any other key: no change. Unmapped make or break codes: no change.
- Latency: `keycode` and `key_event` update on the cycle after `byte_rdy`, i.e. 2 cycles after the `fe` that sampled the stop bit.
- `rx_err` is asserted in the cycle after the offending `fe` or the timeout, and never coincides with `byte_rdy` for the same frame.
- Reset, including mid-frame: clear `clk_f` to 1, the FSMs to IDLE/NORM, `keycode` to 0, `key_event` to 0, `rx_err` to 0, and all counters to 0. A frame already in progress at reset release is not completed, because no start bit is seen. Its remaining edges are consumed as noise, or as a new frame whose errors are reported through `rx_err`.

Test Plan:
- Send frame 0x23 (parity 0, stop 1) -> `keycode`=0x07 two cycles after the last `fe`, with one `key_event` pulse.
- Send 0x42, then 0x42 again (typematic), then 0xF0, 0x42 -> `keycode` 0x0E with a single `key_event`, then 0x00 with a second `key_event`.
- Hold J (0x3B -> 0x0D), press K (0x42 -> 0x0E), then release J (0xF0, 0x3B) -> `keycode` stays 0x0E.
- Send 0x29 with the parity bit flipped -> `rx_err` pulses once and `keycode` stays 0. Repeat with stop=0 -> same result.
- Send start bit plus 3 data bits, then idle for TIMEOUT_CYCLES -> `rx_err` pulses. A following good 0x2B frame gives `keycode`=0x09.
- Send 0xE0, 0x29 and then 0xE0, 0xF0, 0x29 -> `keycode` stays 0. Glitch `ps2_clk` low for FILTER_LEN-1 cycles -> no bit is sampled. Assert Reset mid-DATA -> all outputs are 0 on the next cycle.
